parking_gate_ctrl: RTL and testbench
====================================

PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

Interface
REQ-001 The block SHALL have parameter CAPACITY, default 99, meaning the maximum occupancy (legal range 1..99).
REQ-002 The block SHALL have parameter OPEN_TIMEOUT, default 500_000_000, meaning the cycles the gate stays open waiting for a car.
REQ-003 The block SHALL have parameter CLOSE_DELAY, default 200_000_000, meaning the cycles the gate stays open after a car passes.
REQ-004 The block SHALL have parameter DENY_CYCLES, default 100_000_000, meaning the duration of the deny indication.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port entry_req, input, 1 bit: debounced entry-button level.
REQ-008 The block SHALL have port vehicle_entered, input, 1 bit: one-cycle pulse from the car-detection FSM.
REQ-009 The block SHALL have port vehicle_exited, input, 1 bit: one-cycle pulse from the car-detection FSM.
REQ-010 The block SHALL have port gate_open, output, 1 bit: barrier drive.
REQ-011 The block SHALL have port deny, output, 1 bit: "lot full" indicator.
REQ-012 The block SHALL have port full, output, 1 bit: high when occupancy equals CAPACITY.
REQ-013 The block SHALL have port occupancy, output, 7 bits: binary car count.
REQ-014 The block SHALL have port unidades, output, 4 bits: BCD ones digit of occupancy.
REQ-015 The block SHALL have port decenas, output, 4 bits: BCD tens digit of occupancy.
REQ-016 The block SHALL have port err_over, output, 1 bit: sticky flag, set by an increment attempted at CAPACITY.
REQ-017 The block SHALL have port err_under, output, 1 bit: sticky flag, set by a decrement attempted at 0.

Function
REQ-018 Occupancy SHALL update on the clock edge after a pulse: +1 on vehicle_entered, -1 on vehicle_exited.
REQ-019 Simultaneous vehicle_entered and vehicle_exited SHALL leave occupancy unchanged and set no error flag.
REQ-020 An increment at CAPACITY SHALL saturate (no change) and set err_over.
REQ-021 A decrement at 0 SHALL saturate and set err_under.
REQ-022 err_over and err_under SHALL clear only on reset.
REQ-023 full SHALL be combinational from the occupancy register: (occupancy == CAPACITY).
REQ-024 unidades and decenas SHALL be registered and SHALL lag occupancy by exactly one cycle.
REQ-025 entry_req SHALL be rising-edge detected internally; a level held high SHALL NOT retrigger the gate.
REQ-026 The gate FSM SHALL have four states: CLOSED, OPEN, CLOSING_WAIT and DENIED, each with one shared down-counter timer.
REQ-027 In CLOSED, an entry_req rise with full=0 SHALL go to OPEN and load OPEN_TIMEOUT-1; a rise with full=1 SHALL go to DENIED and load DENY_CYCLES-1.
REQ-028 In OPEN, vehicle_entered SHALL go to CLOSING_WAIT and load CLOSE_DELAY-1; otherwise the FSM SHALL go to CLOSED when the timer reaches 0.
REQ-029 CLOSING_WAIT SHALL go to CLOSED when the timer reaches 0.
REQ-030 A vehicle_entered pulse in CLOSING_WAIT SHALL reload CLOSE_DELAY-1 (tailgating car).
REQ-031 DENIED SHALL go to CLOSED when the timer reaches 0; entry_req rises in DENIED SHALL be ignored.
REQ-032 Moore outputs: gate_open SHALL be 1 in OPEN and CLOSING_WAIT only; deny SHALL be 1 in DENIED only; both SHALL be registered.
REQ-033 vehicle_exited SHALL never affect the gate FSM.

Reset
REQ-034 While reset_n=0, occupancy, unidades, decenas, the timer, gate_open, deny, err_over, err_under and the edge-detect register SHALL be 0, and the FSM SHALL be in CLOSED.
REQ-035 Assertion of reset_n mid-operation, including with the gate open, SHALL close the gate immediately (asynchronously).
REQ-036 The first entry_req rise after release SHALL require entry_req to have been sampled low at least once.

Structure
REQ-037 A shared package parking_pkg SHALL hold the gate state enum (gate_state_t) and the occupancy width constant OCC_W=7.
REQ-038 Binary-to-BCD conversion (0..99) SHALL be a separate combinational sub-module bin2bcd_2d; the output registers SHALL stay in parking_gate_ctrl.
REQ-039 The timer SHALL be sized by $clog2 of the largest timing parameter.

Verification
REQ-040 The bench SHALL cover the normal entry: with parameters reduced to 10/5/4, entry_req rise -> gate_open=1 next cycle; vehicle_entered at cycle 3 -> occupancy 1, decenas:unidades 0:1 one cycle later, gate closes 5 cycles after the pulse.
REQ-041 The bench SHALL cover open timeout: entry_req rise with no car -> gate_open high exactly 10 cycles, occupancy stays 0.
REQ-042 The bench SHALL cover a full lot: CAPACITY=3, three entries, then entry_req -> full=1, deny=1 for 4 cycles, gate_open stays 0; a further vehicle_entered -> occupancy 3, err_over=1.
REQ-043 The bench SHALL cover underflow and simultaneous pulses: vehicle_exited at 0 -> err_under=1, occupancy 0; vehicle_entered and vehicle_exited together at 5 -> occupancy 5.
REQ-044 The bench SHALL cover BCD carry: occupancy 9 plus one entry -> decenas=1, unidades=0; then one exit -> 0:9.
REQ-045 The bench SHALL cover reset mid-operation: reset_n low during CLOSING_WAIT -> gate_open=0 asynchronously, all outputs 0, and the FSM in CLOSED after release.

Source files
------------

// File: rtl/parking_pkg.sv
// Parking gate controller shared definitions.
//   gate_state_t : barrier FSM state encoding
//   OCC_W        : width of the binary occupancy count (0..99)
//   timer_width  : width of the shared gate timer for a given set of
//                  cycle counts (largest count, never below one bit)
package parking_pkg;

  localparam int OCC_W = 7;

  typedef enum logic [1:0] {
    CLOSED       = 2'd0,
    OPEN         = 2'd1,
    CLOSING_WAIT = 2'd2,
    DENIED       = 2'd3
  } gate_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // A counter loaded with N-1 needs $clog2(N) bits; keep at least one bit.
  function automatic int timer_width(input int a, input int b, input int c);
    int w;
    w = $clog2(max3(a, b, c));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/parking_gate_ctrl_bin2bcd_2d.sv
// Two-digit binary-to-BCD converter, purely combinational.
//   bin_i  : binary value, legal range 0..99
//   tens_o : BCD tens digit
//   ones_o : BCD ones digit
module bin2bcd_2d
  import parking_pkg::*;
(
  input  logic [OCC_W-1:0] bin_i,
  output logic [3:0]       tens_o,
  output logic [3:0]       ones_o
);

  always_comb begin
    tens_o = 4'd0;
    for (int t = 1; t <= 9; t++) begin
      if (bin_i >= OCC_W'(t * 10)) tens_o = 4'(t);
    end
    // The true remainder is below 10, so modulo-16 arithmetic on the low
    // nibble gives it exactly.
    ones_o = bin_i[3:0] - (tens_o * 4'd10);
  end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking gate controller: occupancy counter with saturation and sticky
// error flags, registered BCD display digits, and the barrier FSM.
//   clk             : single clock
//   reset_n         : asynchronous active-low reset
//   entry_req       : debounced entry button level (rising edge opens gate)
//   vehicle_entered : one-cycle pulse, car passed inwards
//   vehicle_exited  : one-cycle pulse, car left the lot
//   gate_open       : barrier drive (registered)
//   deny            : "lot full" indicator (registered)
//   full            : occupancy == CAPACITY
//   occupancy       : binary car count
//   unidades/decenas: BCD ones/tens of occupancy, one cycle behind it
//   err_over        : sticky, entry counted while already at CAPACITY
//   err_under       : sticky, exit counted while already empty
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY     = 99,
  parameter int OPEN_TIMEOUT = 500_000_000,
  parameter int CLOSE_DELAY  = 200_000_000,
  parameter int DENY_CYCLES  = 100_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             entry_req,
  input  logic             vehicle_entered,
  input  logic             vehicle_exited,
  output logic             gate_open,
  output logic             deny,
  output logic             full,
  output logic [OCC_W-1:0] occupancy,
  output logic [3:0]       unidades,
  output logic [3:0]       decenas,
  output logic             err_over,
  output logic             err_under
);

  localparam int TMR_W = timer_width(OPEN_TIMEOUT, CLOSE_DELAY, DENY_CYCLES);
  localparam logic [TMR_W-1:0] OPEN_LOAD  = TMR_W'(OPEN_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] CLOSE_LOAD = TMR_W'(CLOSE_DELAY - 1);
  localparam logic [TMR_W-1:0] DENY_LOAD  = TMR_W'(DENY_CYCLES - 1);
  localparam logic [OCC_W-1:0] CAP        = OCC_W'(CAPACITY);

  logic [OCC_W-1:0] occ_q, occ_d;
  logic             err_over_q, err_over_d;
  logic             err_under_q, err_under_d;
  logic [3:0]       uni_q, dec_q;
  logic [3:0]       bcd_tens, bcd_ones;
  logic             entry_low_q;
  logic             entry_rise;
  gate_state_t      state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             gate_open_q, deny_q;

  // Occupancy counter; simultaneous in/out pulses cancel.
  always_comb begin
    occ_d       = occ_q;
    err_over_d  = err_over_q;
    err_under_d = err_under_q;
    if (vehicle_entered && !vehicle_exited) begin
      if (occ_q == CAP) err_over_d = 1'b1;
      else              occ_d      = occ_q + 1'b1;
    end else if (vehicle_exited && !vehicle_entered) begin
      if (occ_q == '0) err_under_d = 1'b1;
      else             occ_d       = occ_q - 1'b1;
    end
  end

  bin2bcd_2d u_bcd (
    .bin_i  (occ_q),
    .tens_o (bcd_tens),
    .ones_o (bcd_ones)
  );

  // entry_low_q remembers that the button was seen low on the previous
  // edge; being cleared by reset, a button held through reset must be
  // released once before it can open the gate.
  assign entry_rise = entry_req & entry_low_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      CLOSED: begin
        if (entry_rise) begin
          if (full) begin
            state_d = DENIED;
            timer_d = DENY_LOAD;
          end else begin
            state_d = OPEN;
            timer_d = OPEN_LOAD;
          end
        end
      end
      OPEN: begin
        if (vehicle_entered) begin
          state_d = CLOSING_WAIT;
          timer_d = CLOSE_LOAD;
        end else if (timer_q == '0) begin
          state_d = CLOSED;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      CLOSING_WAIT: begin
        // A tailgating car restarts the close delay.
        if (vehicle_entered)       timer_d = CLOSE_LOAD;
        else if (timer_q == '0)    state_d = CLOSED;
        else                       timer_d = timer_q - 1'b1;
      end
      DENIED: begin
        if (timer_q == '0) state_d = CLOSED;
        else               timer_d = timer_q - 1'b1;
      end
      default: begin
        state_d = CLOSED;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q       <= '0;
      err_over_q  <= 1'b0;
      err_under_q <= 1'b0;
      uni_q       <= '0;
      dec_q       <= '0;
      entry_low_q <= 1'b0;
      state_q     <= CLOSED;
      timer_q     <= '0;
      gate_open_q <= 1'b0;
      deny_q      <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      err_over_q  <= err_over_d;
      err_under_q <= err_under_d;
      uni_q       <= bcd_ones;
      dec_q       <= bcd_tens;
      entry_low_q <= ~entry_req;
      state_q     <= state_d;
      timer_q     <= timer_d;
      // Moore outputs registered from the next state so they align with it.
      gate_open_q <= (state_d == OPEN) || (state_d == CLOSING_WAIT);
      deny_q      <= (state_d == DENIED);
    end
  end

  assign full      = (occ_q == CAP);
  assign occupancy = occ_q;
  assign unidades  = uni_q;
  assign decenas   = dec_q;
  assign err_over  = err_over_q;
  assign err_under = err_under_q;
  assign gate_open = gate_open_q;
  assign deny      = deny_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl: two instances (capacity 99 and 3) with
// reduced timing 10/5/4, directed stimulus, expectations queued per cycle.
module tb_parking_gate_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_a, ve_a, vx_a, req_b, ve_b, vx_b;
  logic       go_a, dn_a, fl_a, eo_a, eu_a, go_b, dn_b, fl_b, eo_b, eu_b;
  logic [6:0] occ_a, occ_b;
  logic [3:0] uni_a, dec_a, uni_b, dec_b;

  always #5 clk = ~clk;

  parking_gate_ctrl #(.CAPACITY(99), .OPEN_TIMEOUT(10), .CLOSE_DELAY(5), .DENY_CYCLES(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .entry_req(req_a), .vehicle_entered(ve_a),
    .vehicle_exited(vx_a), .gate_open(go_a), .deny(dn_a), .full(fl_a),
    .occupancy(occ_a), .unidades(uni_a), .decenas(dec_a), .err_over(eo_a), .err_under(eu_a));

  parking_gate_ctrl #(.CAPACITY(3), .OPEN_TIMEOUT(10), .CLOSE_DELAY(5), .DENY_CYCLES(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .entry_req(req_b), .vehicle_entered(ve_b),
    .vehicle_exited(vx_b), .gate_open(go_b), .deny(dn_b), .full(fl_b),
    .occupancy(occ_b), .unidades(uni_b), .decenas(dec_b), .err_over(eo_b), .err_under(eu_b));

  // Field codes: 0 gate_open 1 deny 2 full 3 occupancy 4 unidades 5 decenas 6 err_over 7 err_under
  typedef struct {
    int    cyc;
    int    dut;
    int    fld;
    int    exp;
    string name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] get(input int d, input int f);
    logic [31:0] r;
    r = '0;
    if (d == 0) begin
      case (f)
        0: r = 32'(go_a);  1: r = 32'(dn_a);  2: r = 32'(fl_a);  3: r = 32'(occ_a);
        4: r = 32'(uni_a); 5: r = 32'(dec_a); 6: r = 32'(eo_a);  default: r = 32'(eu_a);
      endcase
    end else begin
      case (f)
        0: r = 32'(go_b);  1: r = 32'(dn_b);  2: r = 32'(fl_b);  3: r = 32'(occ_b);
        4: r = 32'(uni_b); 5: r = 32'(dec_b); 6: r = 32'(eo_b);  default: r = 32'(eu_b);
      endcase
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_at(input int d, input int f, input int at, input int v, input string n);
    exp_t e;
    e.cyc = at; e.dut = d; e.fld = f; e.exp = v; e.name = n;
    sb.push_back(e);
  endtask

  // Monitor: on each falling edge, compare every expectation due now.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc < cyc) begin
          checks++;
          failures++;
          $display("FAIL %s: expectation for cycle %0d never sampled", sb[i].name, sb[i].cyc);
          sb.delete(i);
        end else if (sb[i].cyc == cyc) begin
          check(sb[i].name, get(sb[i].dut, sb[i].fld), sb[i].exp);
          sb.delete(i);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int d, input logic e, input logic x);
    if (d == 0) begin ve_a = e; vx_a = x; end
    else        begin ve_b = e; vx_b = x; end
    step();
    ve_a = 1'b0; vx_a = 1'b0; ve_b = 1'b0; vx_b = 1'b0;
  endtask

  initial begin
    int b;
    reset_n = 1'b0;
    req_a = 1'b0; ve_a = 1'b0; vx_a = 1'b0;
    req_b = 1'b0; ve_b = 1'b0; vx_b = 1'b0;
    step(); step();

    // Reset state of every output on both instances.
    for (int d = 0; d < 2; d++)
      for (int f = 0; f < 8; f++) expect_at(d, f, cyc, 0, "reset_state");
    step();
    reset_n = 1'b1;
    step(); step();

    // Open timeout: no car, gate high exactly 10 cycles.
    b = cyc;
    req_a = 1'b1;
    expect_at(0, 0, b,      0, "timeout_gate_before");
    expect_at(0, 0, b + 1,  1, "timeout_gate_open");
    expect_at(0, 0, b + 10, 1, "timeout_gate_last");
    expect_at(0, 0, b + 11, 0, "timeout_gate_closed");
    expect_at(0, 0, b + 12, 0, "timeout_no_retrigger");
    expect_at(0, 3, b + 11, 0, "timeout_occ");
    repeat (12) step();
    req_a = 1'b0;
    step(); step();

    // Underflow at zero.
    b = cyc;
    expect_at(0, 7, b,     0, "under_before");
    expect_at(0, 7, b + 1, 1, "under_flag");
    expect_at(0, 3, b + 1, 0, "under_occ");
    pulse(0, 1'b0, 1'b1);
    step();

    // Normal entry with a car on the third cycle.
    b = cyc;
    expect_at(0, 0, b,      0, "entry_gate_before");
    expect_at(0, 0, b + 1,  1, "entry_gate_open");
    expect_at(0, 3, b + 2,  0, "entry_occ_before");
    expect_at(0, 3, b + 3,  1, "entry_occ");
    expect_at(0, 4, b + 3,  0, "entry_uni_lag");
    expect_at(0, 4, b + 4,  1, "entry_uni");
    expect_at(0, 5, b + 4,  0, "entry_dec");
    expect_at(0, 0, b + 7,  1, "entry_gate_still_open");
    expect_at(0, 0, b + 8,  0, "entry_gate_closed");
    expect_at(0, 0, b + 10, 0, "entry_no_retrigger");
    req_a = 1'b1;
    step(); step();
    pulse(0, 1'b1, 1'b0);
    repeat (8) step();
    req_a = 1'b0;
    step();

    // Count up to 5, then simultaneous pulses.
    repeat (4) begin pulse(0, 1'b1, 1'b0); step(); end
    b = cyc;
    expect_at(0, 3, b + 1, 5, "simul_occ");
    expect_at(0, 6, b + 1, 0, "simul_no_over");
    expect_at(0, 7, b + 1, 1, "under_sticky");
    expect_at(0, 4, b + 2, 5, "simul_uni");
    pulse(0, 1'b1, 1'b1);
    step();

    // Count up to 9, then BCD carry and borrow.
    repeat (4) begin pulse(0, 1'b1, 1'b0); step(); end
    b = cyc;
    expect_at(0, 3, b, 9, "nine_occ");
    expect_at(0, 4, b, 9, "nine_uni");
    expect_at(0, 5, b, 0, "nine_dec");
    expect_at(0, 3, b + 1, 10, "carry_occ");
    expect_at(0, 4, b + 1, 9,  "carry_uni_lag");
    expect_at(0, 4, b + 2, 0,  "carry_uni");
    expect_at(0, 5, b + 2, 1,  "carry_dec");
    pulse(0, 1'b1, 1'b0);
    step();
    b = cyc;
    expect_at(0, 3, b + 1, 9, "borrow_occ");
    expect_at(0, 5, b + 1, 1, "borrow_dec_lag");
    expect_at(0, 4, b + 2, 9, "borrow_uni");
    expect_at(0, 5, b + 2, 0, "borrow_dec");
    pulse(0, 1'b0, 1'b1);
    step();

    // Full lot on the capacity-3 instance.
    repeat (3) begin pulse(1, 1'b1, 1'b0); step(); end
    b = cyc;
    expect_at(1, 3, b, 3, "full_occ");
    expect_at(1, 2, b, 1, "full_flag");
    expect_at(1, 1, b,     0, "deny_before");
    expect_at(1, 1, b + 1, 1, "deny_on");
    expect_at(1, 1, b + 4, 1, "deny_last");
    expect_at(1, 1, b + 5, 0, "deny_off");
    expect_at(1, 1, b + 6, 0, "deny_no_retrigger");
    expect_at(1, 0, b + 1, 0, "deny_gate_1");
    expect_at(1, 0, b + 3, 0, "deny_gate_3");
    expect_at(1, 0, b + 6, 0, "deny_gate_6");
    req_b = 1'b1;
    step();
    req_b = 1'b0;
    step();
    req_b = 1'b1;  // rise while denied must be ignored
    repeat (6) step();
    b = cyc;
    expect_at(1, 6, b,     0, "over_before");
    expect_at(1, 6, b + 1, 1, "over_flag");
    expect_at(1, 3, b + 1, 3, "over_occ");
    expect_at(1, 2, b + 1, 1, "over_full");
    pulse(1, 1'b1, 1'b0);
    req_b = 1'b0;
    step(); step();

    // Reset during CLOSING_WAIT.
    b = cyc;
    expect_at(0, 0, b + 2, 1, "cw_gate_open");
    expect_at(0, 0, b + 3, 1, "cw_gate_open2");
    expect_at(0, 3, b + 3, 10, "cw_occ");
    req_a = 1'b1;
    step();
    pulse(0, 1'b1, 1'b0);
    step();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_gate_open", 32'(go_a), 0);
    check("async_deny",      32'(dn_a), 0);
    check("async_occ",       32'(occ_a), 0);
    check("async_uni",       32'(uni_a), 0);
    check("async_dec",       32'(dec_a), 0);
    check("async_err_over",  32'(eo_b), 0);
    check("async_err_under", 32'(eu_a), 0);
    check("async_full_b",    32'(fl_b), 0);
    step(); step();
    reset_n = 1'b1;
    b = cyc;
    expect_at(0, 0, b + 1, 0, "held_req_no_open");
    expect_at(0, 0, b + 2, 0, "held_req_no_open2");
    step(); step();
    req_a = 1'b0;
    step();
    b = cyc;
    expect_at(0, 0, b + 1, 1, "post_reset_open");
    expect_at(0, 1, b + 1, 0, "post_reset_no_deny");
    req_a = 1'b1;
    step(); step();
    req_a = 1'b0;

    // Drain the scoreboard with a bound.
    for (int i = 0; i < 40 && sb.size() > 0; i++) step();
    while (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s: pending expectation at end, cycle %0d", sb[0].name, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
